// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem transaction.
// Buffers one instruction for IF/ID and raises stall_fetch.
module ifetch_ctrl #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(32'h0040_0000),
  parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_pc_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              instr_valid_o,
  output logic              stall_fetch_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_READY
  } state_e;

  state_e            state_q, state_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;

  logic              redir;
  logic              capture;
  logic              advance;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state logic; a redirect outranks gnt, rvalid and en_pc
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ: begin
        if (!redirect_i && imem_gnt_i)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          discard_d = 1'b0;
          if (redirect_i || discard_q)
            state_d = S_REQ;
          else
            state_d = S_READY;
        end else if (redirect_i) begin
          discard_d = 1'b1;
        end
      end
      S_READY: begin
        if (redirect_i || en_pc_i)
          state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode and datapath strobes
  always_comb begin
    imem_req_o = (state_q == S_REQ) && !redirect_i;
    redir      = redirect_i && (state_q != S_IDLE);
    capture    = (state_q == S_WAIT) && imem_rvalid_i
                 && !discard_q && !redirect_i;
    advance    = (state_q == S_READY) && en_pc_i && !redirect_i;
  end

  // Datapath next values: PC update and instruction buffer
  always_comb begin
    pc_d    = pc_q;
    instr_d = NOP_INSTR;
    valid_d = (state_d == S_READY);
    if (redir)
      pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    else if (advance)
      pc_d = pc_q + ADDR_W'(4);
    if (capture)
      instr_d = imem_rdata_i;
    else if (valid_d)
      instr_d = instr_q;
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign stall_fetch_o = ~valid_q;

  a_one_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == S_WAIT) |-> !imem_req_o);

  a_addr_aligned : assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_addr_o[1:0] == 2'b00);

  a_addr_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (imem_req_o && !imem_gnt_i && !redirect_i)
      |=> $stable(imem_addr_o));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: per-cycle vector table
// plus a hand sequence for reset in the middle of a fetch.
module tb_ifetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PA  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_pc_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        stall_fetch_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_pc_i       (en_pc_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o),
    .stall_fetch_o (stall_fetch_o)
  );

  typedef struct {
    logic        en;
    logic        rd;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        val;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(
    input logic en, input logic rd, input logic [31:0] rpc,
    input logic gnt, input logic rv, input logic [31:0] rdata,
    input logic req, input logic [31:0] addr, input logic val,
    input logic [31:0] instr, input logic [31:0] pc);
    vec_t v;
    v.en = en; v.rd = rd; v.rpc = rpc;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.req = req; v.addr = addr; v.val = val;
    v.instr = instr; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_outs(input string tag, input logic req,
                          input logic [31:0] addr, input logic val,
                          input logic [31:0] instr, input logic [31:0] pc);
    chk({tag, " req"}, 32'(imem_req_o), 32'(req));
    if (req) chk({tag, " addr"}, imem_addr_o, addr);
    chk({tag, " valid"}, 32'(instr_valid_o), 32'(val));
    chk({tag, " stall"}, 32'(stall_fetch_o), 32'(!val));
    chk({tag, " instr"}, instr_o, instr);
    chk({tag, " pc"}, pc_o, pc);
  endtask

  vec_t tbl[30];

  initial begin
    logic [31:0] pb, pc1, pd, pe, pf, pg;
    pb  = 32'h0040_0004;
    pc1 = 32'h0040_0100;
    pd  = 32'h0040_0200;
    pe  = 32'h0040_0300;
    pf  = 32'h0040_0400;
    pg  = 32'hFFFF_FFFC;
    // fetch, hold, advance
    tbl[0]  = mk(0,0,0,0,0,0,                      0,PA,0,NOP,PA);
    tbl[1]  = mk(0,0,0,1,0,0,                      1,PA,0,NOP,PA);
    tbl[2]  = mk(0,0,0,0,1,32'h0050_0093,          0,PA,0,NOP,PA);
    tbl[3]  = mk(0,0,0,0,0,0,                      0,PA,1,32'h0050_0093,PA);
    tbl[4]  = mk(0,0,0,1,1,32'hBAD0_0BAD,          0,PA,1,32'h0050_0093,PA);
    tbl[5]  = mk(0,0,0,0,0,0,                      0,PA,1,32'h0050_0093,PA);
    tbl[6]  = mk(0,0,0,0,0,0,                      0,PA,1,32'h0050_0093,PA);
    tbl[7]  = mk(0,0,0,0,0,0,                      0,PA,1,32'h0050_0093,PA);
    tbl[8]  = mk(1,0,0,0,0,0,                      0,PA,1,32'h0050_0093,PA);
    tbl[9]  = mk(0,0,0,0,0,0,                      1,pb,0,NOP,pb);
    tbl[10] = mk(1,0,0,1,0,0,                      1,pb,0,NOP,pb);
    // redirect in WAIT, late response dropped
    tbl[11] = mk(0,1,32'h0040_0100,0,0,0,          0,pb,0,NOP,pb);
    tbl[12] = mk(1,0,0,0,1,32'hDEAD_BEEF,          0,pc1,0,NOP,pc1);
    tbl[13] = mk(0,0,0,1,0,0,                      1,pc1,0,NOP,pc1);
    // redirect coincident with rvalid, unaligned target
    tbl[14] = mk(0,1,32'h0040_0203,0,1,32'h1111_1111,0,pc1,0,NOP,pc1);
    tbl[15] = mk(0,0,0,1,0,0,                      1,pd,0,NOP,pd);
    tbl[16] = mk(0,0,0,0,1,32'h00A0_0113,          0,pd,0,NOP,pd);
    tbl[17] = mk(0,0,0,0,0,0,                      0,pd,1,32'h00A0_0113,pd);
    // redirect from READY beats en_pc
    tbl[18] = mk(1,1,32'h0040_0300,0,0,0,          0,pd,1,32'h00A0_0113,pd);
    // delayed gnt, then redirect while ungranted
    tbl[19] = mk(0,0,0,0,0,0,                      1,pe,0,NOP,pe);
    tbl[20] = mk(0,0,0,0,0,0,                      1,pe,0,NOP,pe);
    tbl[21] = mk(0,0,0,0,0,0,                      1,pe,0,NOP,pe);
    tbl[22] = mk(0,1,32'h0040_0400,1,0,0,          0,pe,0,NOP,pe);
    tbl[23] = mk(0,0,0,1,0,0,                      1,pf,0,NOP,pf);
    tbl[24] = mk(0,0,0,0,1,32'h1234_5678,          0,pf,0,NOP,pf);
    // PC wrap at top of address space
    tbl[25] = mk(0,1,32'hFFFF_FFFF,0,0,0,          0,pf,1,32'h1234_5678,pf);
    tbl[26] = mk(0,0,0,1,0,0,                      1,pg,0,NOP,pg);
    tbl[27] = mk(0,0,0,0,1,32'hCAFE_0013,          0,pg,0,NOP,pg);
    tbl[28] = mk(1,0,0,0,0,0,                      0,pg,1,32'hCAFE_0013,pg);
    tbl[29] = mk(0,0,0,0,0,0,                      1,32'h0,0,NOP,32'h0);

    repeat (2) @(negedge clk);
    #1;
    chk_outs("reset", 1'b0, PA, 1'b0, NOP, PA);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst_n         = 1'b1;
      en_pc_i       = tbl[i].en;
      redirect_i    = tbl[i].rd;
      redirect_pc_i = tbl[i].rpc;
      imem_gnt_i    = tbl[i].gnt;
      imem_rvalid_i = tbl[i].rv;
      imem_rdata_i  = tbl[i].rdata;
      #1;
      chk_outs($sformatf("row%0d", i), tbl[i].req, tbl[i].addr,
               tbl[i].val, tbl[i].instr, tbl[i].pc);
    end

    // reset asserted mid-WAIT, stale response afterwards
    @(negedge clk);
    en_pc_i = 1'b0; redirect_i = 1'b0;
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    #2;
    chk("pre-rst req", 32'(imem_req_o), 32'(1'b0));
    rst_n = 1'b0;
    #1;
    chk_outs("async rst", 1'b0, PA, 1'b0, NOP, PA);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    chk_outs("rel idle", 1'b0, PA, 1'b0, NOP, PA);
    @(negedge clk);
    #1;
    chk_outs("stale rv", 1'b1, PA, 1'b0, NOP, PA);
    imem_rvalid_i = 1'b0;
    imem_gnt_i    = 1'b1;
    @(negedge clk);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0070_0093;
    #1;
    chk_outs("post wait", 1'b0, PA, 1'b0, NOP, PA);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    #1;
    chk_outs("post ready", 1'b0, PA, 1'b1, 32'h0070_0093, PA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
